// File: rtl/rab_mh_fifo_if.sv
// rab_mh_fifo_if: handshake/status bundle between a miss-handling FIFO and
// its user. The master side pushes/pops; the slave side is the FIFO itself.
interface rab_mh_fifo_if #(
  parameter int DATA_WIDTH = 20,
  parameter int CNT_WIDTH  = 6
);
  logic [DATA_WIDTH-1:0] din;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;
  logic [CNT_WIDTH-1:0]  count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output din, wr_en, rd_en,
    input  dout, full, empty, count, overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/rab_mh_fifo.sv
// rab_mh_fifo: synchronous first-word-fall-through FIFO for RAB miss-handling
// records. Storage is a synchronous-read array (block RAM friendly); the read
// register dout_q is also the FWFT output stage, flagged valid by dv.
// Optional status outputs (count/overflow/underflow) are built only when the
// macro RAB_MH_FIFO_STATUS_EN is defined; otherwise they are tied to 0.
module rab_mh_fifo #(
  parameter int DATA_WIDTH = 20,
  parameter int DEPTH      = 32
) (
  input  logic          clk,
  input  logic          rst,
  rab_mh_fifo_if.slave  bus
);

  localparam int ADDR_W    = $clog2(DEPTH);
  localparam int CNT_WIDTH = ADDR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CNT_WIDTH-1:0]  wr_ptr;
  logic [CNT_WIDTH-1:0]  rd_ptr;
  logic [CNT_WIDTH-1:0]  occ;
  logic [CNT_WIDTH-1:0]  fetch_ptr;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  dv;
  logic                  full_w;
  logic                  push;
  logic                  pop;
  logic                  refill;

  // Occupancy counts the head word held in dout_q; the next entry to fetch
  // sits one past the head when the head is valid. Comparing against the
  // registered wr_ptr means a word written this edge is not fetched this edge.
  always_comb begin
    occ       = wr_ptr - rd_ptr;
    full_w    = (occ == CNT_WIDTH'(DEPTH));
    push      = bus.wr_en & ~full_w;
    pop       = bus.rd_en & dv;
    fetch_ptr = rd_ptr + {{ADDR_W{1'b0}}, dv};
    refill    = (~dv | pop) & (fetch_ptr != wr_ptr);
  end

  // Pointer and head-valid control
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dv     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CNT_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + CNT_WIDTH'(1);
      if (refill)   dv <= 1'b1;
      else if (pop) dv <= 1'b0;
    end
  end

  // Storage write port; contents are not reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= bus.din;
  end

  // Synchronous read into the FWFT output register
  always_ff @(posedge clk) begin
    if (rst)         dout_q <= '0;
    else if (refill) dout_q <= mem[fetch_ptr[ADDR_W-1:0]];
  end

  assign bus.dout  = dout_q;
  assign bus.empty = ~dv;
  assign bus.full  = full_w;

`ifdef RAB_MH_FIFO_STATUS_EN
  logic ovf_q;
  logic unf_q;

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.wr_en & full_w) ovf_q <= 1'b1;
      if (bus.rd_en & ~dv)    unf_q <= 1'b1;
    end
  end

  assign bus.count     = occ;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`else
  assign bus.count     = '0;
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

endmodule

// File: doc/rab_mh_fifo.md
# rab_mh_fifo

Synchronous first-word-fall-through FIFO that buffers RAB miss-handling records (miss address bits or miss ID) between the miss-detection logic and the AXI-Lite configuration register block. Two instances sit in that register block: the address FIFO and the ID FIFO. Both are written by a detected miss or by a config-port write, and popped by config-port reads. Storage is a synchronous-read array so it maps to block RAM; the read register doubles as the FWFT output stage.

## Interface
- DATA_WIDTH, 20, entry width; matches MHR_WIDTH of the parent.
- DEPTH, 32, number of entries; power of two, ≥ 4.
- CNT_WIDTH, log2(DEPTH)+1, width of `count`; derived, not overridden.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high. Parent drives it with inverted s_axi_aresetn.
- din  in  DATA_WIDTH  write data.
- wr_en  in  1  push request; parent already gates it with ~full.
- rd_en  in  1  pop request; acknowledges the word currently on `dout`.
- dout  out  DATA_WIDTH  head word; valid whenever empty=0.
- full  out  1  DEPTH words stored.
- empty  out  1  no valid word on `dout`.
- count  out  CNT_WIDTH  words stored, 0..DEPTH (status option).
- overflow  out  1  sticky: push attempted while full (status option).
- underflow  out  1  sticky: pop attempted while empty (status option).

## Operation
- State:
  - `wr_ptr`, `rd_ptr`, each log2(DEPTH)+1 bits, with a wrap bit; pointers wrap modulo 2·DEPTH.
  - `mem[DEPTH]`.
  - Output register `dout_q` and valid flag `dv`.
- Occupancy is wr_ptr − rd_ptr and includes the word held in `dout_q`. full = (occupancy == DEPTH). empty = ~dv.
- Push: wr_en & ~full writes din to mem[wr_ptr] and increments wr_ptr. wr_en & full is dropped: no state change.
- Pop: rd_en & dv increments rd_ptr and frees the head entry. rd_en & ~dv is ignored.
- Refill: when (~dv or pop) and an unread entry exists behind the head, `dout_q` loads the next mem entry and dv←1. Otherwise a pop clears dv.
- A word written at edge k is never readable from mem at edge k. There is no write-to-read bypass.
- Simultaneous push and pop:
  - Not full: both happen; occupancy is unchanged.
  - Full: the push is dropped because full is registered state; the pop proceeds.
- Pop with occupancy 1 plus a simultaneous push: empty=1 for exactly one cycle, then the pushed word appears.
- Reset: dout=0, empty=1, full=0, count=0, overflow=0, underflow=0, pointers=0, dv=0. Contents are discarded. Reset dominates wr_en/rd_en in the same cycle.

## Timing
- Write-to-visible latency: push sampled at edge k gives empty=0 and dout=din after edge k+1. Latency is 2 edges from an empty FIFO.
- Pop-to-next-head: with ≥ 2 words stored, rd_en at edge k presents the next word after edge k; empty stays 0. Sustained one pop per cycle is supported.
- full asserts after the edge that stores the DEPTH-th word. It deasserts after the edge of the first pop.
- count updates on the same edge as the push/pop that changes it.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: RAB_MH_FIFO_STATUS_EN.
- Defined:
  - `count` reflects occupancy.
  - overflow sets on wr_en & full; underflow sets on rd_en & empty.
  - Both flags clear only on rst.
- Undefined:
  - count, overflow and underflow are tied to 0.
  - Their logic is not synthesized; ports remain present so the instantiation is unchanged.
  - FIFO data behaviour is identical either way.

## Test plan
- Reset, then push 0x12345 at edge k → empty=1 after edge k, empty=0 and dout=0x12345 after edge k+1, count=1; pop → empty=1 and count=0 next edge.
- Push 32 words 0x00000..0x0001F back-to-back → full=1 after the 32nd; a 33rd push with 0xFFFFF is dropped and overflow=1 (STATUS_EN); popping 32 times returns 0x00000..0x0001F in order, one per cycle.
- Push and pop every cycle for 100 cycles with occupancy 1..3 (exercises pointer wrap past 64) → dout sequence matches pushes, count constant, no empty glitch.
- Occupancy 1 with head 0xAAAAA, simultaneous pop and push of 0x55555 → empty=1 for one cycle, then dout=0x55555, count=1.
- Full FIFO, simultaneous push 0x77777 and pop → push dropped, count=31, full=0; the last word read is the 32nd original, never 0x77777.
- Assert rst with 10 words stored and wr_en=1 → after that edge empty=1, count=0, flags=0; the next push is read back correctly. Pop while empty → underflow=1 (STATUS_EN) or 0 (undefined), state unchanged.
